// File: rtl/lfsr_step_ctrl_if.sv
// Job request / response channel between job logic and lfsr_step_ctrl.
// master: job issuer and response consumer; slave: the sequencer.
`timescale 1ns/1ps
interface lfsr_step_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_seed;
    logic [CNT_W-1:0] req_steps;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_state;
    logic             rsp_zero_seed;

    modport master (
        output req_valid, req_seed, req_steps, rsp_ready,
        input  req_ready, rsp_valid, rsp_state, rsp_zero_seed
    );

    modport slave (
        input  req_valid, req_seed, req_steps, rsp_ready,
        output req_ready, rsp_valid, rsp_state, rsp_zero_seed
    );
endinterface

// File: rtl/lfsr_step_ctrl.sv
// Sequencer for one external LFSR: loads a seed, enables it for exactly N
// cycles, then presents the final state on a valid/ready response channel.
// Optional feature macro: LFSR_ZERO_GUARD_EN (replace all-zero seeds with 1).
`timescale 1ns/1ps
module lfsr_step_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_b,
    lfsr_step_ctrl_if.slave  bus,
    input  logic             abort,
    output logic             busy,
    output logic [WIDTH-1:0] lfsr_in,
    output logic             lfsr_load,
    output logic             lfsr_enable,
    input  logic [WIDTH-1:0] lfsr_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
`ifdef LFSR_ZERO_GUARD_EN
    logic             zero_q, zero_d;
`endif

    // State, seed and step-counter registers.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= IDLE;
            seed_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            remaining_q <= remaining_d;
        end
    end

`ifdef LFSR_ZERO_GUARD_EN
    // Remembers that the current job's seed was substituted.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end
`endif

    // Next-state logic: job capture, single load cycle, N enable cycles, hold result.
    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        remaining_d = remaining_q;
`ifdef LFSR_ZERO_GUARD_EN
        zero_d      = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    remaining_d = bus.req_steps;
                    state_d     = LOAD;
`ifdef LFSR_ZERO_GUARD_EN
                    // An all-zero seed would lock an XOR LFSR at zero.
                    if (bus.req_seed == '0) begin
                        seed_d = WIDTH'(1);
                        zero_d = 1'b1;
                    end else begin
                        seed_d = bus.req_seed;
                        zero_d = 1'b0;
                    end
`else
                    seed_d      = bus.req_seed;
`endif
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (remaining_q != '0) begin
                    state_d = RUN;
                end else begin
                    state_d = DONE;
                end
            end
            RUN: begin
                // remaining_q is at least 1 here, so the decrement cannot wrap.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state; LFSR is frozen outside RUN.
    always_comb begin
        bus.req_ready     = 1'b0;
        bus.rsp_valid     = 1'b0;
        bus.rsp_state     = '0;
        bus.rsp_zero_seed = 1'b0;
        lfsr_load         = 1'b0;
        lfsr_enable       = 1'b0;
        lfsr_in           = seed_q;
        busy              = (state_q != IDLE);
        case (state_q)
            IDLE: bus.req_ready = 1'b1;
            LOAD: lfsr_load     = 1'b1;
            RUN:  lfsr_enable   = 1'b1;
            DONE: begin
                bus.rsp_valid     = 1'b1;
                bus.rsp_state     = lfsr_out;
`ifdef LFSR_ZERO_GUARD_EN
                bus.rsp_zero_seed = zero_q;
`endif
            end
            default: ;
        endcase
    end

endmodule
